// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock/tick generator.
// Each channel divides the base clock by a programmable period with a programmable
// high time. Config is written into a shadow and applied at a period boundary.
// A global sync pulse restarts every running channel at count 0.

module mcd_channel #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    logic [CNT_W-1:0] cnt, act_period, act_high, shd_period, shd_high;
    logic             run;

    logic [CNT_W-1:0] cnt_n, period_n, high_n;
    logic             run_n, at_wrap, boundary, apply;

    // Next-state: boundary detection, shadow apply and counter advance.
    // act_period-1 is compared (not cnt+1) so the maximum period does not overflow.
    always_comb begin
        at_wrap  = run && (cnt == act_period - ONE);
        boundary = run && (sync || at_wrap);
        // a write landing on the boundary itself waits for the next one
        apply    = pending && !wr && (!run || boundary);
        period_n = apply ? shd_period : act_period;
        high_n   = apply ? shd_high   : act_high;
        run_n    = en && (period_n != ZERO);
        if (!run_n || !run || boundary)
            cnt_n = ZERO;
        else
            cnt_n = cnt + ONE;
    end

    // State and registered outputs; outputs are decoded from the next count so
    // they line up with cnt in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            act_period <= '0;
            act_high   <= '0;
            shd_period <= '0;
            shd_high   <= '0;
            pending    <= 1'b0;
            run        <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            act_period <= period_n;
            act_high   <= high_n;
            run        <= run_n;
            clk_out    <= run_n && (cnt_n < high_n);
            tick       <= run_n && (cnt_n == ZERO);
            if (wr) begin
                shd_period <= wr_period;
                shd_high   <= wr_high;
                pending    <= 1'b1;
            end else if (apply) begin
                pending    <= 1'b0;
            end
        end
    end
endmodule

module multi_clock_divider #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);
    // One independent divider per channel; only sync and the write port are shared.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == 4'(c));

        mcd_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (ch_en[c]),
            .sync      (sync),
            .wr        (wr),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .clk_out   (clk_out[c]),
            .tick      (tick[c]),
            .pending   (cfg_pending[c])
        );
    end
endmodule
